vid_pll_supervisor: RTL and testbench

VID_PLL_SUPERVISOR -- requirements
Module: vid_pll_supervisor

---
 rtl/vid_pll_supervisor.sv | 190 +++++++++++++++++++
 tb/tb_vid_pll_supervisor.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_pll_supervisor.sv
// ----------------------------------------------------------------------------
// vid_pll_supervisor
//
// Supervises a video PLL from the free-running reference clock.  The PLL is
// held in reset for a fixed number of cycles, then given a bounded time to
// lock.  Once lock has been stable long enough, the video-domain reset is
// released.  Loss of lock while running sends the PLL back through a reset
// cycle.  Timeouts and lock losses are recorded in sticky status flags.
//
// Parameters
//   PLL_RST_CYCLES      refclk cycles pll_rst is held high per attempt (>=1)
//   LOCK_STABLE_CYCLES  consecutive locked cycles before video release (>=1)
//   LOCK_TIMEOUT_CYCLES cycles waiting for lock before re-resetting (>=2)
//
// Ports
//   refclk        in   reference clock, the only clock of the block
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   clr_status    in   single-cycle pulse clearing the sticky flags
//   pll_rst       out  active-high reset to the PLL
//   vid_rst_n     out  active-low video reset request, high only in RUN
//   lock_lost     out  sticky: lock dropped while in RUN
//   lock_timeout  out  sticky: PLL failed to lock in time
//   relock_cnt    out  [7:0] saturating count of RUN-to-LOST events
//                      (only when VID_PLL_SUPERVISOR_RELOCK_CNT_EN is defined)
//
// Configuration macro
//   VID_PLL_SUPERVISOR_RELOCK_CNT_EN  adds the relock_cnt port and counter
// ----------------------------------------------------------------------------
module vid_pll_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clr_status,
    output logic       pll_rst,
    output logic       vid_rst_n,
    output logic       lock_lost,
    output logic       lock_timeout
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_cnt
`endif
);

    // One counter is shared by every state, so it is sized for the largest
    // interval any state has to measure.
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_LOST      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             locked_s_q, locked_s_d;
    logic             timeout_evt_q, timeout_evt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             vid_rst_n_q, vid_rst_n_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_timeout_q, lock_timeout_d;
    logic             lost_evt;
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
    logic [7:0]       relock_cnt_q, relock_cnt_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves a value unassigned, which would otherwise infer a latch.
        sync1_d       = pll_locked;
        locked_s_d    = sync1_q;
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        timeout_evt_d = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = S_RESET_PLL;
                    timeout_evt_d = 1'b1;
                end
            end
            S_STABLE: begin
                // A single unlocked cycle restarts the wait without touching
                // the PLL; the stable run must then begin again from zero.
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s_q) begin
                    state_d = S_LOST;
                end
            end
            S_LOST: begin
                state_d = S_RESET_PLL;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state so they change together
        // with the state register.
        pll_rst_d   = (state_d == S_RESET_PLL);
        vid_rst_n_d = (state_d == S_RUN);

        // Flags trail the state change by one cycle; a set beats a clear.
        lost_evt       = (state_q == S_LOST);
        lock_lost_d    = lost_evt | (lock_lost_q & ~clr_status);
        lock_timeout_d = timeout_evt_q | (lock_timeout_q & ~clr_status);

`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
        relock_cnt_d = relock_cnt_q;
        if (lost_evt && (relock_cnt_q != 8'hFF)) begin
            relock_cnt_d = relock_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RESET_PLL;
            cnt_q          <= '0;
            sync1_q        <= 1'b0;
            locked_s_q     <= 1'b0;
            timeout_evt_q  <= 1'b0;
            pll_rst_q      <= 1'b1;
            vid_rst_n_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            lock_timeout_q <= 1'b0;
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
            relock_cnt_q   <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before this edge, independent of statement order.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync1_q        <= sync1_d;
            locked_s_q     <= locked_s_d;
            timeout_evt_q  <= timeout_evt_d;
            pll_rst_q      <= pll_rst_d;
            vid_rst_n_q    <= vid_rst_n_d;
            lock_lost_q    <= lock_lost_d;
            lock_timeout_q <= lock_timeout_d;
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
            relock_cnt_q   <= relock_cnt_d;
`endif
        end
    end

    assign pll_rst      = pll_rst_q;
    assign vid_rst_n    = vid_rst_n_q;
    assign lock_lost    = lock_lost_q;
    assign lock_timeout = lock_timeout_q;
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
    assign relock_cnt   = relock_cnt_q;
`endif

endmodule

// File: tb/tb_vid_pll_supervisor.sv
// ----------------------------------------------------------------------------
// tb_vid_pll_supervisor
//
// Directed and randomized stimulus for vid_pll_supervisor with small timing
// parameters.  A behavioural model tracks remaining reset time, wait age,
// stable-run length and run/lost status, and every cycle's outputs are
// compared against it, alongside explicit latency and interval checks.
// ----------------------------------------------------------------------------
module tb_vid_pll_supervisor;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       clr_status;
    logic       pll_rst;
    logic       vid_rst_n;
    logic       lock_lost;
    logic       lock_timeout;
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
    logic [7:0] relock_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_rst_left;   // remaining cycles of the current PLL reset pulse
    int m_wait_age;   // cycles spent waiting for lock
    int m_stable;     // consecutive locked cycles, -1 when not qualifying
    bit m_run;
    bit m_lost;
    bit m_to_pend;    // timeout happened, flag lands on the next edge
    bit m_s1;
    bit m_ls;
    bit m_lock_lost;
    bit m_lock_to;
    int m_relock;

    vid_pll_supervisor #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STB),
        .LOCK_TIMEOUT_CYCLES(P_TO)
    ) dut (
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
        .relock_cnt  (relock_cnt),
`endif
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .clr_status  (clr_status),
        .pll_rst     (pll_rst),
        .vid_rst_n   (vid_rst_n),
        .lock_lost   (lock_lost),
        .lock_timeout(lock_timeout)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rst_left  = P_RST;
        m_wait_age  = 0;
        m_stable    = -1;
        m_run       = 1'b0;
        m_lost      = 1'b0;
        m_to_pend   = 1'b0;
        m_s1        = 1'b0;
        m_ls        = 1'b0;
        m_lock_lost = 1'b0;
        m_lock_to   = 1'b0;
        m_relock    = 0;
    endtask

    // Advance the model by one refclk edge using the inputs present at it.
    task automatic model_edge();
        bit ls, lost_set, to_set;
        ls        = m_ls;
        lost_set  = m_lost;
        to_set    = m_to_pend;
        m_to_pend = 1'b0;

        if (m_lost) begin
            m_lost     = 1'b0;
            m_rst_left = P_RST;
        end else if (m_rst_left > 0) begin
            m_rst_left--;
            m_wait_age = 0;
        end else if (m_run) begin
            if (!ls) begin
                m_run  = 1'b0;
                m_lost = 1'b1;
            end
        end else if (m_stable >= 0) begin
            if (!ls) begin
                m_stable   = -1;
                m_wait_age = 0;
            end else begin
                m_stable++;
                if (m_stable == P_STB) begin
                    m_stable = -1;
                    m_run    = 1'b1;
                end
            end
        end else begin
            if (ls) begin
                m_stable = 0;
            end else begin
                m_wait_age++;
                if (m_wait_age == P_TO) begin
                    m_rst_left = P_RST;
                    m_to_pend  = 1'b1;
                end
            end
        end

        m_lock_lost = lost_set | (m_lock_lost & ~clr_status);
        m_lock_to   = to_set | (m_lock_to & ~clr_status);
        if (lost_set && m_relock < 255) m_relock++;

        m_ls = m_s1;
        m_s1 = pll_locked;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pll_rst"},      {7'd0, pll_rst},      {7'd0, (m_rst_left > 0)});
        check({tag, ".vid_rst_n"},    {7'd0, vid_rst_n},    {7'd0, m_run});
        check({tag, ".lock_lost"},    {7'd0, lock_lost},    {7'd0, m_lock_lost});
        check({tag, ".lock_timeout"}, {7'd0, lock_timeout}, {7'd0, m_lock_to});
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
        check({tag, ".relock_cnt"},   relock_cnt,           8'(m_relock));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        compare_all(tag);
    endtask

    initial begin
        int n_high;
        int first_vid;
        int n;
        int hold;
        bit ok;
        bit prev;
        int rises[$];

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        clr_status = 1'b0;
        model_reset();

        // Reset state with clock running
        repeat (3) @(negedge refclk);
        compare_all("reset");

        // Power-up: lock appears at cycle 10 and stays
        rst_n = 1'b1;
        compare_all("release");
        n_high    = 0;
        first_vid = -1;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) pll_locked = 1'b1;
            if (pll_rst) n_high++;
            step("powerup");
            if (vid_rst_n && first_vid < 0) first_vid = c + 1;
        end
        check("powerup.pll_rst_cycles", 8'(n_high), 8'(P_RST));
        // 2 synchronizer edges, 1 decision edge, then P_STB stable edges
        check("powerup.vid_rise_cycle", 8'(first_vid), 8'(10 + 3 + P_STB));

        // Lock drop in RUN: video reset falls 3 edges later
        pll_locked = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step("lost");
            n++;
            if (!vid_rst_n) break;
        end
        check("lost.fall_latency", 8'(n), 8'd3);

        // Hold unlocked: reset pulse every P_RST + P_TO cycles
        prev   = pll_rst;
        n_high = 0;
        for (int i = 0; i < 120; i++) begin
            step("timeout");
            if (i == 0) begin
                check("lost.lock_lost", {7'd0, lock_lost}, 8'd1);
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
                check("lost.relock_cnt", relock_cnt, 8'd1);
`endif
            end
            if (pll_rst && !prev) rises.push_back(i);
            if (pll_rst) n_high++;
            prev = pll_rst;
        end
        check("timeout.num_pulses", 8'(rises.size()), 8'd4);
        if (rises.size() >= 4) begin
            check("timeout.period1", 8'(rises[1] - rises[0]), 8'(P_RST + P_TO));
            check("timeout.period2", 8'(rises[2] - rises[1]), 8'(P_RST + P_TO));
            check("timeout.period3", 8'(rises[3] - rises[2]), 8'(P_RST + P_TO));
        end
        check("timeout.high_cycles", 8'(n_high), 8'(4 * P_RST));
        check("timeout.flag", {7'd0, lock_timeout}, 8'd1);

        // Clear pulse with no coinciding event clears both flags
        clr_status = 1'b1;
        step("clear");
        clr_status = 1'b0;
        check("clear.lock_lost", {7'd0, lock_lost}, 8'd0);
        check("clear.lock_timeout", {7'd0, lock_timeout}, 8'd0);

        // Glitch after 5 stable cycles: back to waiting, no PLL reset
        pll_locked = 1'b1;
        ok = 1'b0;
        for (int g = 0; g < 60; g++) begin
            if (m_stable == 5) begin
                ok = 1'b1;
                break;
            end
            step("glitch.wait");
        end
        check("glitch.reached_stable5", {7'd0, ok}, 8'd1);
        pll_locked = 1'b0;
        step("glitch");
        n_high = pll_rst ? 1 : 0;
        pll_locked = 1'b1;
        first_vid = -1;
        for (int j = 2; j <= 40; j++) begin
            step("glitch");
            if (pll_rst) n_high++;
            if (vid_rst_n && first_vid < 0) first_vid = j;
        end
        check("glitch.no_pll_rst", 8'(n_high), 8'd0);
        // Two in-flight locked edges, 1 unlocked edge, 1 re-entry edge,
        // then P_STB fresh stable edges
        check("glitch.vid_rise_cycle", 8'(first_vid), 8'(4 + P_STB));

        // 300 RUN/LOST round trips; one LOST coincides with a clear
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                clr_status = 1'b1;
                step("cycle.preclear");
                clr_status = 1'b0;
                check("cycle.precleared", {7'd0, lock_lost}, 8'd0);
            end
            pll_locked = 1'b0;
            ok = 1'b0;
            for (int g = 0; g < 10; g++) begin
                step("cycle.drop");
                if (m_lost) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("cycle.reached_lost", {7'd0, ok}, 8'd1);
            if (!ok) break;
            if (k == 150) begin
                clr_status = 1'b1;
                step("cycle.setwins");
                clr_status = 1'b0;
                check("cycle.set_wins", {7'd0, lock_lost}, 8'd1);
            end
            pll_locked = 1'b1;
            ok = 1'b0;
            for (int g = 0; g < 60; g++) begin
                step("cycle.relock");
                if (m_run) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("cycle.reached_run", {7'd0, ok}, 8'd1);
            if (!ok) break;
        end
`ifdef VID_PLL_SUPERVISOR_RELOCK_CNT_EN
        check("cycle.relock_saturated", relock_cnt, 8'd255);
`endif

        // Randomized lock behaviour and clear pulses
        hold = 0;
        for (int r = 0; r < 1500; r++) begin
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                hold       = int'($urandom_range(1, 40));
            end
            hold--;
            clr_status = ($urandom_range(0, 15) == 0);
            step("random");
        end
        clr_status = 1'b0;

        // Asynchronous reset in the middle of RUN
        pll_locked = 1'b1;
        ok = 1'b0;
        for (int g = 0; g < 80; g++) begin
            if (m_run) begin
                ok = 1'b1;
                break;
            end
            step("midrun.wait");
        end
        check("midrun.reached_run", {7'd0, ok}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun.async_vid_rst_n", {7'd0, vid_rst_n}, 8'd0);
        check("midrun.async_pll_rst", {7'd0, pll_rst}, 8'd1);
        model_reset();
        compare_all("midrun.async");
        @(negedge refclk);
        compare_all("midrun.held");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("midrun.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
